// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - RV32I decode/control stage: ID/EX register, load-use detect, halt drain FSM
module ctrl_pipe #(
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_inst,
  input  logic        i_trap,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_memread,
  output logic        o_hazard_stall,
  output logic        o_valid,
  output logic [5:0]  o_inst_format,
  output logic        o_RegWrite,
  output logic        o_ALUSrc1,
  output logic        o_ALUSrc2,
  output logic        o_lui,
  output logic        o_MemtoReg,
  output logic        o_Jump,
  output logic        o_Branch,
  output logic [1:0]  o_ALUop,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_halt_tag,
  output logic        o_illegal,
  output logic        o_retire_halt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  localparam logic [31:0] EBREAK     = 32'h00100073;
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] fmt;
    logic       reg_write;
    logic       alu_src1;
    logic       alu_src2;
    logic       lui;
    logic       mem_to_reg;
    logic       jump;
    logic       branch;
    logic [1:0] alu_op;
    logic       dmem_ren;
    logic       dmem_wen;
    logic [3:0] dmem_mask;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       halt_tag;
    logic       illegal;
  } idex_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  idex_t      idex_q, idex_d;

  ctrl_t      dec_ctrl;
  logic       dec_legal;
  logic       uses_rs1;
  logic       uses_rs2;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       is_ebreak;
  logic       hazard;
  logic       squash_illegal;
  logic       halting;

  assign opcode    = i_inst[6:0];
  assign funct3    = i_inst[14:12];
  assign rs1       = i_inst[19:15];
  assign rs2       = i_inst[24:20];
  assign rd        = i_inst[11:7];
  assign is_ebreak = (i_inst == EBREAK);

  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_legal          = 1'b1;
        dec_ctrl.fmt       = FMT_R;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b00;
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b1;
      end
      OP_IALU: begin
        dec_legal          = 1'b1;
        dec_ctrl.fmt       = FMT_I;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.alu_op    = 2'b01;
        uses_rs1           = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl.fmt        = FMT_I;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src2   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.dmem_ren   = 1'b1;
        dec_ctrl.alu_op     = 2'b10;
        uses_rs1            = 1'b1;
        case (funct3)
          3'b000, 3'b100: begin dec_legal = 1'b1; dec_ctrl.dmem_mask = 4'b0001; end
          3'b001, 3'b101: begin dec_legal = 1'b1; dec_ctrl.dmem_mask = 4'b0011; end
          3'b010:         begin dec_legal = 1'b1; dec_ctrl.dmem_mask = 4'b1111; end
          default:        dec_legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec_ctrl.fmt      = FMT_S;
        dec_ctrl.alu_src2 = 1'b1;
        dec_ctrl.dmem_wen = 1'b1;
        dec_ctrl.alu_op   = 2'b10;
        uses_rs1          = 1'b1;
        uses_rs2          = 1'b1;
        case (funct3)
          3'b000:  begin dec_legal = 1'b1; dec_ctrl.dmem_mask = 4'b0001; end
          3'b001:  begin dec_legal = 1'b1; dec_ctrl.dmem_mask = 4'b0011; end
          3'b010:  begin dec_legal = 1'b1; dec_ctrl.dmem_mask = 4'b1111; end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        dec_legal       = 1'b1;
        dec_ctrl.fmt    = FMT_B;
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b11;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
      end
      OP_LUI: begin
        dec_legal          = 1'b1;
        dec_ctrl.fmt       = FMT_U;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.lui       = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_AUIPC: begin
        dec_legal          = 1'b1;
        dec_ctrl.fmt       = FMT_U;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src1  = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_JAL: begin
        dec_legal          = 1'b1;
        dec_ctrl.fmt       = FMT_J;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src1  = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_JALR: begin
        dec_legal          = 1'b1;
        dec_ctrl.fmt       = FMT_I;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        uses_rs1           = 1'b1;
      end
      OP_SYSTEM: begin
        dec_legal    = is_ebreak;
        dec_ctrl.fmt = FMT_I;
      end
      default: dec_legal = 1'b0;
    endcase
    // An illegal encoding carries no control; its register fields still pass through
    if (!dec_legal) dec_ctrl = '0;
  end

  assign hazard = i_valid && (state_q == ST_RUN) && i_ex_memread && (i_ex_rd != 5'd0) &&
                  ((uses_rs1 && (rs1 == i_ex_rd)) || (uses_rs2 && (rs2 == i_ex_rd)));
  assign squash_illegal = i_valid && !dec_legal && !HALT_ON_ILLEGAL;
  assign halting        = i_valid && (is_ebreak || i_trap || (!dec_legal && HALT_ON_ILLEGAL));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idex_d  = '0;
    if (i_stall) begin
      idex_d = idex_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!i_flush && !hazard && i_valid) begin
            if (squash_illegal) begin
              idex_d.illegal = 1'b1;
            end else begin
              idex_d.valid = 1'b1;
              idex_d.ctrl  = dec_ctrl;
              idex_d.rs1   = rs1;
              idex_d.rs2   = rs2;
              idex_d.rd    = rd;
              if (halting) begin
                idex_d.halt_tag       = 1'b1;
                idex_d.ctrl.reg_write = 1'b0;
                idex_d.ctrl.dmem_ren  = 1'b0;
                idex_d.ctrl.dmem_wen  = 1'b0;
                state_d               = ST_DRAIN;
                cnt_d                 = DRAIN_LOAD;
              end
            end
          end
        end
        ST_DRAIN: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_HALTED;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idex_q  <= idex_d;
    end
  end

  assign o_hazard_stall = hazard;
  assign o_valid        = idex_q.valid;
  assign o_inst_format  = idex_q.ctrl.fmt;
  assign o_RegWrite     = idex_q.ctrl.reg_write;
  assign o_ALUSrc1      = idex_q.ctrl.alu_src1;
  assign o_ALUSrc2      = idex_q.ctrl.alu_src2;
  assign o_lui          = idex_q.ctrl.lui;
  assign o_MemtoReg     = idex_q.ctrl.mem_to_reg;
  assign o_Jump         = idex_q.ctrl.jump;
  assign o_Branch       = idex_q.ctrl.branch;
  assign o_ALUop        = idex_q.ctrl.alu_op;
  assign o_dmem_ren     = idex_q.ctrl.dmem_ren;
  assign o_dmem_wen     = idex_q.ctrl.dmem_wen;
  assign o_dmem_mask    = idex_q.ctrl.dmem_mask;
  assign o_rs1          = idex_q.rs1;
  assign o_rs2          = idex_q.rs2;
  assign o_rd           = idex_q.rd;
  assign o_halt_tag     = idex_q.halt_tag;
  assign o_illegal      = idex_q.illegal;
  assign o_retire_halt  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe: decode table, corner sequences, random vs model
module tb_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic [5:0] fmt;
    logic [6:0] ctl;   // {RegWrite, ALUSrc1, ALUSrc2, lui, MemtoReg, Jump, Branch}
    logic [1:0] aluop;
    logic       ren;
    logic       wen;
    logic [3:0] mask;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       halt_tag;
    logic       illegal;
    logic       retire;
  } out_t;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  fmt;
    logic [6:0]  ctl;
    logic [1:0]  aluop;
    logic        ren;
    logic        wen;
    logic [3:0]  mask;
  } vec_t;

  localparam logic [31:0] ADD    = 32'h002081B3;
  localparam logic [31:0] EBRK   = 32'h00100073;
  localparam logic [31:0] SW     = 32'h0020A023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, trap, stall, flush, memread;
  logic [31:0] inst;
  logic [4:0]  ex_rd;

  logic       a_hz, a_valid, a_rw, a_s1, a_s2, a_lui, a_m2r, a_j, a_b, a_ren, a_wen, a_tag, a_ill, a_ret;
  logic [5:0] a_fmt;
  logic [1:0] a_aluop;
  logic [3:0] a_mask;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic       b_hz, b_valid, b_rw, b_s1, b_s2, b_lui, b_m2r, b_j, b_b, b_ren, b_wen, b_tag, b_ill, b_ret;
  logic [5:0] b_fmt;
  logic [1:0] b_aluop;
  logic [3:0] b_mask;
  logic [4:0] b_rs1, b_rs2, b_rd;

  ctrl_pipe #(.DRAIN_CYCLES(4), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_inst(inst), .i_trap(trap), .i_stall(stall),
    .i_flush(flush), .i_ex_rd(ex_rd), .i_ex_memread(memread), .o_hazard_stall(a_hz),
    .o_valid(a_valid), .o_inst_format(a_fmt), .o_RegWrite(a_rw), .o_ALUSrc1(a_s1), .o_ALUSrc2(a_s2),
    .o_lui(a_lui), .o_MemtoReg(a_m2r), .o_Jump(a_j), .o_Branch(a_b), .o_ALUop(a_aluop),
    .o_dmem_ren(a_ren), .o_dmem_wen(a_wen), .o_dmem_mask(a_mask), .o_rs1(a_rs1), .o_rs2(a_rs2),
    .o_rd(a_rd), .o_halt_tag(a_tag), .o_illegal(a_ill), .o_retire_halt(a_ret)
  );

  ctrl_pipe #(.DRAIN_CYCLES(2), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_inst(inst), .i_trap(trap), .i_stall(stall),
    .i_flush(flush), .i_ex_rd(ex_rd), .i_ex_memread(memread), .o_hazard_stall(b_hz),
    .o_valid(b_valid), .o_inst_format(b_fmt), .o_RegWrite(b_rw), .o_ALUSrc1(b_s1), .o_ALUSrc2(b_s2),
    .o_lui(b_lui), .o_MemtoReg(b_m2r), .o_Jump(b_j), .o_Branch(b_b), .o_ALUop(b_aluop),
    .o_dmem_ren(b_ren), .o_dmem_wen(b_wen), .o_dmem_mask(b_mask), .o_rs1(b_rs1), .o_rs2(b_rs2),
    .o_rd(b_rd), .o_halt_tag(b_tag), .o_illegal(b_ill), .o_retire_halt(b_ret)
  );

  out_t act_a, act_b;
  assign act_a = {a_valid, a_fmt, a_rw, a_s1, a_s2, a_lui, a_m2r, a_j, a_b, a_aluop, a_ren, a_wen,
                  a_mask, a_rs1, a_rs2, a_rd, a_tag, a_ill, a_ret};
  assign act_b = {b_valid, b_fmt, b_rw, b_s1, b_s2, b_lui, b_m2r, b_j, b_b, b_aluop, b_ren, b_wen,
                  b_mask, b_rs1, b_rs2, b_rd, b_tag, b_ill, b_ret};

  int checks = 0;
  int errors = 0;

  out_t m_out [2];
  bit   m_acc [2];
  int   m_n   [2];
  int   dr    [2];
  bit   hoi   [2];
  vec_t tv    [13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic out_t ref_decode(input logic [31:0] x, output bit legal, output bit u1, output bit u2);
    out_t       o;
    logic [2:0] f3;
    int         bytes;
    o     = '0;
    f3    = x[14:12];
    bytes = 1 << f3[1:0];
    legal = 1'b1;
    u1    = 1'b0;
    u2    = 1'b0;
    o.valid = 1'b1;
    o.rs1   = x[19:15];
    o.rs2   = x[24:20];
    o.rd    = x[11:7];
    case (x[6:0])
      7'b0110011: begin o.fmt = 6'b000001; o.ctl = 7'b1000000; o.aluop = 2'b00; u1 = 1; u2 = 1; end
      7'b0010011: begin o.fmt = 6'b000010; o.ctl = 7'b1010000; o.aluop = 2'b01; u1 = 1; end
      7'b0000011: begin
        o.fmt = 6'b000010; o.ctl = 7'b1010100; o.aluop = 2'b10; o.ren = 1'b1; u1 = 1;
        o.mask = 4'((1 << bytes) - 1);
        legal  = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
      end
      7'b0100011: begin
        o.fmt = 6'b000100; o.ctl = 7'b0010000; o.aluop = 2'b10; o.wen = 1'b1; u1 = 1; u2 = 1;
        o.mask = 4'((1 << bytes) - 1);
        legal  = (f3 < 3'd3);
      end
      7'b1100011: begin o.fmt = 6'b001000; o.ctl = 7'b0000001; o.aluop = 2'b11; u1 = 1; u2 = 1; end
      7'b0110111: begin o.fmt = 6'b010000; o.ctl = 7'b1011000; o.aluop = 2'b10; end
      7'b0010111: begin o.fmt = 6'b010000; o.ctl = 7'b1110000; o.aluop = 2'b10; end
      7'b1101111: begin o.fmt = 6'b100000; o.ctl = 7'b1110010; o.aluop = 2'b10; end
      7'b1100111: begin o.fmt = 6'b000010; o.ctl = 7'b1010010; o.aluop = 2'b10; u1 = 1; end
      7'b1110011: begin o.fmt = 6'b000010; legal = (x == EBRK); end
      default:    legal = 1'b0;
    endcase
    if (!legal) begin
      o.fmt = '0; o.ctl = '0; o.aluop = '0; o.ren = 1'b0; o.wen = 1'b0; o.mask = '0;
    end
    return o;
  endfunction

  // Halt tracking: once accepted, count unstalled edges; halted when the count reaches the drain length
  task automatic model_step(input int k, output bit hz);
    bit   legal, u1, u2;
    out_t d;
    d  = ref_decode(inst, legal, u1, u2);
    hz = valid && !m_acc[k] && memread && (ex_rd != 5'd0) &&
         ((u1 && inst[19:15] == ex_rd) || (u2 && inst[24:20] == ex_rd));
    if (rst) begin
      m_out[k] = '0; m_acc[k] = 1'b0; m_n[k] = 0;
    end else if (!stall) begin
      if (m_acc[k]) begin
        m_n[k]++;
        m_out[k] = '0;
        m_out[k].retire = (m_n[k] >= dr[k]);
      end else if (flush || hz || !valid) begin
        m_out[k] = '0;
      end else if (!legal && !hoi[k]) begin
        m_out[k] = '0;
        m_out[k].illegal = 1'b1;
      end else begin
        m_out[k] = d;
        if (inst == EBRK || trap || !legal) begin
          m_out[k].halt_tag = 1'b1;
          m_out[k].ctl[6]   = 1'b0;
          m_out[k].ren      = 1'b0;
          m_out[k].wen      = 1'b0;
          m_acc[k] = 1'b1;
          m_n[k]   = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    bit hz [2];
    #1;
    for (int k = 0; k < 2; k++) model_step(k, hz[k]);
    check("hazard_a", a_hz, hz[0]);
    check("hazard_b", b_hz, hz[1]);
    @(posedge clk);
    #1;
    check("model_a", act_a, m_out[0]);
    check("model_b", act_b, m_out[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; trap = 1'b0; memread = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
    logic [31:0] hi;
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    f3 = 3'($urandom);
    hi = $urandom;
    case ($urandom_range(0, 19))
      0:  return {hi[31:20], r1, f3, rd, 7'b0010011};
      1:  return {hi[31:20], r1, f3, rd, 7'b0000011};
      2:  return {hi[31:20], r1, f3, rd, 7'b0000011};
      3:  return {hi[31:25], r2, r1, f3, hi[11:7], 7'b0100011};
      4:  return {hi[31:25], r2, r1, f3[1:0] == 2'b11 ? 3'b010 : {1'b0, f3[1:0]}, hi[11:7], 7'b0100011};
      5:  return {hi[31:25], r2, r1, f3, hi[11:7], 7'b1100011};
      6:  return {hi[31:12], rd, 7'b0110111};
      7:  return {hi[31:12], rd, 7'b0010111};
      8:  return {hi[31:12], rd, 7'b1101111};
      9:  return {hi[31:20], r1, 3'b000, rd, 7'b1100111};
      10: return EBRK;
      11: return {hi[31:7], 7'b1110011};
      12: return {hi[31:7], 7'b0001111};
      13: return {hi[31:7], 7'b1111111};
      default: return {hi[31:25], r2, r1, f3, rd, 7'b0110011};
    endcase
  endfunction

  initial begin
    dr[0] = 4; dr[1] = 2; hoi[0] = 1'b1; hoi[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin m_out[k] = '0; m_acc[k] = 1'b0; m_n[k] = 0; end
    tv[0]  = '{ADD,          6'b000001, 7'b1000000, 2'b00, 1'b0, 1'b0, 4'b0000};
    tv[1]  = '{32'h00500093, 6'b000010, 7'b1010000, 2'b01, 1'b0, 1'b0, 4'b0000};
    tv[2]  = '{32'h00812283, 6'b000010, 7'b1010100, 2'b10, 1'b1, 1'b0, 4'b1111};
    tv[3]  = '{32'h0000C383, 6'b000010, 7'b1010100, 2'b10, 1'b1, 1'b0, 4'b0001};
    tv[4]  = '{32'h00219203, 6'b000010, 7'b1010100, 2'b10, 1'b1, 1'b0, 4'b0011};
    tv[5]  = '{32'h00208023, 6'b000100, 7'b0010000, 2'b10, 1'b0, 1'b1, 4'b0001};
    tv[6]  = '{32'h00209023, 6'b000100, 7'b0010000, 2'b10, 1'b0, 1'b1, 4'b0011};
    tv[7]  = '{SW,           6'b000100, 7'b0010000, 2'b10, 1'b0, 1'b1, 4'b1111};
    tv[8]  = '{32'h00208063, 6'b001000, 7'b0000001, 2'b11, 1'b0, 1'b0, 4'b0000};
    tv[9]  = '{32'h123452B7, 6'b010000, 7'b1011000, 2'b10, 1'b0, 1'b0, 4'b0000};
    tv[10] = '{32'h00001317, 6'b010000, 7'b1110000, 2'b10, 1'b0, 1'b0, 4'b0000};
    tv[11] = '{32'h000000EF, 6'b100000, 7'b1110010, 2'b10, 1'b0, 1'b0, 4'b0000};
    tv[12] = '{32'h00008067, 6'b000010, 7'b1010010, 2'b10, 1'b0, 1'b0, 4'b0000};

    rst = 1'b1; valid = 1'b0; inst = '0; trap = 1'b0; stall = 1'b0; flush = 1'b0;
    memread = 1'b0; ex_rd = '0;
    cycle();
    cycle();
    check("reset_a", act_a, 40'h0);
    check("reset_b", act_b, 40'h0);
    rst = 1'b0;

    inst = ADD; valid = 1'b1;
    cycle();
    check("add_fields", {a_valid, a_fmt, a_rw, a_aluop, a_rs1, a_rs2, a_rd},
          {1'b1, 6'b000001, 1'b1, 2'b00, 5'd1, 5'd2, 5'd3});

    for (int i = 0; i < 13; i++) begin
      inst = tv[i].inst;
      cycle();
      check($sformatf("decode_%0d", i),
            {a_valid, a_fmt, a_rw, a_s1, a_s2, a_lui, a_m2r, a_j, a_b, a_aluop, a_ren, a_wen, a_mask},
            {1'b1, tv[i].fmt, tv[i].ctl, tv[i].aluop, tv[i].ren, tv[i].wen, tv[i].mask});
    end

    inst = SW;
    cycle();
    stall = 1'b1; inst = ADD;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold", {a_valid, a_rw, a_wen, a_mask, a_fmt}, {1'b1, 1'b0, 1'b1, 4'b1111, 6'b000100});
    end
    stall = 1'b0;

    inst = 32'h00128333; memread = 1'b1; ex_rd = 5'd5;
    #1;
    check("loaduse_stall", a_hz, 1'b1);
    cycle();
    check("loaduse_bubble", a_valid, 1'b0);
    ex_rd = 5'd0;
    #1;
    check("loaduse_x0", a_hz, 1'b0);
    cycle();
    check("loaduse_x0_valid", a_valid, 1'b1);
    memread = 1'b0;

    do_reset();
    valid = 1'b1; inst = EBRK;
    cycle();
    check("halt_accept", {a_valid, a_tag, a_rw, a_ret}, 4'b1100);
    inst = ADD;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check($sformatf("drain_%0d", k), {a_valid, a_tag, a_ret}, {2'b00, 1'(k == 4)});
    end

    do_reset();
    valid = 1'b1; inst = EBRK;
    cycle();
    inst = ADD;
    for (int k = 1; k <= 5; k++) begin
      stall = (k == 2);
      cycle();
      check($sformatf("drain_stall_%0d", k), a_ret, 1'(k == 5));
    end
    stall = 1'b0;

    do_reset();
    valid = 1'b1; inst = EBRK; flush = 1'b1;
    cycle();
    check("flush_ebreak", {a_valid, a_tag}, 2'b00);
    flush = 1'b0; inst = ADD;
    for (int k = 0; k < 6; k++) cycle();
    check("flush_no_halt", {a_valid, a_ret}, 2'b10);

    do_reset();
    valid = 1'b1; inst = 32'h0000007F;
    cycle();
    check("illegal_pulse", {b_valid, b_ill, b_tag}, 3'b010);
    inst = ADD;
    cycle();
    check("illegal_clear", {b_valid, b_ill}, 2'b10);
    for (int k = 0; k < 4; k++) cycle();
    check("illegal_no_halt", b_ret, 1'b0);

    do_reset();
    valid = 1'b1; inst = EBRK;
    cycle();
    inst = ADD;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("reset_drain", {a_valid, a_ret}, 2'b00);
    rst = 1'b0;
    cycle();
    check("after_reset_add", {a_valid, a_fmt, a_rd, a_ret}, {1'b1, 6'b000001, 5'd3, 1'b0});

    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 59) == 0) || (m_acc[0] && m_acc[1] && $urandom_range(0, 5) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      valid   = ($urandom_range(0, 7) != 0);
      trap    = ($urandom_range(0, 39) == 0);
      memread = ($urandom_range(0, 2) == 0);
      ex_rd   = 5'($urandom_range(0, 7));
      inst    = rand_inst();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Registered decode/control stage for the pipelined RV32I core. It decodes the instruction in ID and latches the control bundle into the ID/EX pipeline register. It also detects load-use hazards, handles stall and flush, and runs a halt state machine. The halt machine drains the pipeline for a parametrised number of cycles after EBREAK, a trap, or optionally an illegal opcode, then raises a sticky o_retire_halt.

Parameters:
DRAIN_CYCLES, 4, non-stalled cycles from acceptance of the halting instruction to o_retire_halt; legal range 1..15.
HALT_ON_ILLEGAL, 1, 1: an unrecognised opcode halts like EBREAK; 0: it is squashed to a bubble and o_illegal pulses.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  i_inst holds a valid instruction in ID
i_inst  in  32  instruction in ID
i_trap  in  1  trap flagged for the instruction in ID
i_stall  in  1  external stall (memory); hold ID/EX register
i_flush  in  1  redirect from EX; squash the instruction in ID
i_ex_rd  in  5  destination register of the instruction in EX
i_ex_memread  in  1  instruction in EX is a load
o_hazard_stall  out  1  combinational load-use stall to IF/ID
o_valid  out  1  ID/EX holds a valid instruction
o_inst_format  out  6  one-hot: R 000001, I 000010, S 000100, B 001000, U 010000, J 100000, none 000000
o_RegWrite, o_ALUSrc1, o_ALUSrc2, o_lui, o_MemtoReg, o_Jump, o_Branch  out  1 each  standard control
o_ALUop  out  2  R 00, I-ALU 01, load/store/U/J/JALR 10, branch 11
o_dmem_ren  out  1  load only
o_dmem_wen  out  1  store only
o_dmem_mask  out  4  byte lanes for load/store, else 0000
o_rs1, o_rs2, o_rd  out  5 each  register fields
o_halt_tag  out  1  ID/EX instruction is the halting instruction
o_illegal  out  1  registered one-cycle pulse on squashed illegal opcode (HALT_ON_ILLEGAL=0)
o_retire_halt  out  1  sticky halt, high in HALTED

Behaviour:
- Reset: all outputs 0 and state RUN. Reset is honoured in any state, including mid-DRAIN and HALTED.
- Latency: one cycle from ID to ID/EX outputs.
- Decode opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111 (lui=1), 0010111, 1101111, 1100111 (I-format, Jump=1), 1110011.
- EBREAK is i_inst == 0x00100073. Any other opcode is illegal; other 1110011 encodings are illegal.
- Masks by funct3:
  - Load: 000/100 → 0001; 001/101 → 0011; 010 → 1111; others illegal.
  - Store: 000 → 0001; 001 → 0011; 010 → 1111; others illegal.
- Register uses: uses_rs1 for R, I-ALU, load, JALR, S and B. uses_rs2 for R, S and B.
- o_hazard_stall = i_valid & state==RUN & i_ex_memread & i_ex_rd!=0 & ((uses_rs1 & rs1==i_ex_rd) | (uses_rs2 & rs2==i_ex_rd)).
- Bubble: o_valid=0, every control output and o_halt_tag = 0; register fields don't-care (drive 0).
- ID/EX update priority, highest first:
  1. i_rst: clear.
  2. i_stall: hold all outputs; FSM counter frozen.
  3. i_flush: bubble; the instruction in ID is ignored by the FSM.
  4. o_hazard_stall: bubble.
  5. state != RUN: bubble, so younger instructions are squashed.
  6. Illegal with HALT_ON_ILLEGAL=0: bubble plus o_illegal pulse.
  7. Otherwise: load the decoded bundle, o_valid = i_valid.
- Halting instruction: accepted (reaches rule 7, i_valid=1) and EBREAK, or i_trap, or illegal with HALT_ON_ILLEGAL=1. It is loaded with o_valid=1, o_halt_tag=1, RegWrite=0, dmem_ren=0, dmem_wen=0.
- FSM:
  - RUN → DRAIN on a halting instruction; counter loads DRAIN_CYCLES.
  - DRAIN: counter decrements each cycle without i_stall. When it decrements from 1 → HALTED. i_flush is ignored by the FSM in DRAIN.
  - HALTED: absorbing until i_rst; o_retire_halt=1 and registered (rises on the edge entering HALTED).
  - With no stalls, o_retire_halt rises exactly DRAIN_CYCLES edges after the acceptance edge.
- Simultaneous halting instruction and o_hazard_stall: the stall wins; the FSM re-evaluates next cycle.
- i_trap with i_valid=0 is ignored.

Test Plan:
- Decode add: i_inst=0x002081B3 (add x3,x1,x2), i_valid=1 → next edge o_valid=1, o_inst_format=000001, o_RegWrite=1, o_ALUop=00, o_rs1=1, o_rs2=2, o_rd=3.
- Load-use: i_ex_memread=1, i_ex_rd=5, i_inst=add x6,x5,x1 → o_hazard_stall=1, next o_valid=0. Repeat with i_ex_rd=0 → o_hazard_stall=0.
- Stores: sb/sh/sw (funct3 000/001/010) → o_dmem_mask 0001/0011/1111, o_dmem_wen=1, o_RegWrite=0. Assert i_stall for 3 cycles → outputs held unchanged.
- Halt drain: DRAIN_CYCLES=4, EBREAK 0x00100073 accepted at edge 10, then add every cycle → o_halt_tag=1 after edge 10, o_valid=0 after edges 11-14, o_retire_halt=1 from edge 14. An i_stall cycle at edge 12 delays the rise to edge 15.
- Flush/illegal: EBREAK with i_flush=1 → bubble, no DRAIN. HALT_ON_ILLEGAL=0 with i_inst=0x0000007F → bubble, o_illegal pulses 1 cycle, o_retire_halt stays 0.
- Reset: i_rst mid-DRAIN (counter 2) → next edge state RUN, o_retire_halt=0, o_valid=0. Following add decodes normally.
